// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_collector
//  Purpose  : Return-path partner of the pipelined ALU. The ALU has no
//             valid/tag signalling and its ARITH, LOGIC and SHIFT paths have
//             different fixed latencies. Each accepted issue books its
//             completion slot in a timing wheel; when the wheel pointer
//             reaches that slot the value on alu_out is captured and
//             presented as a tagged register-file writeback.
//
//  Ports    : clk, rst_n          - clock, asynchronous active-low reset
//             issue_valid         - issue request this cycle
//             issue_opcode[4:0]   - ALU opcode; [4:3] selects the class
//             issue_rd[4:0]       - destination register tag
//             issue_ready         - combinational accept qualifier
//             alu_out[63:0]       - ALU result bus
//             wb_valid            - one-cycle writeback strobe
//             wb_rd[4:0]          - destination tag of completing op
//             wb_data[63:0]       - captured alu_out
//             wb_class[1:0]       - opcode[4:3] of completing op
//             inflight_cnt        - scheduled, not-yet-completed ops
//             illegal_op          - registered pulse on class-11 issue
//
//  Options  : DEST_HAZARD_EN - when defined, a per-register busy vector
//             stalls issue to a destination that still has an op in flight.
//
//  Revision : 1.0 - initial release
// ============================================================================
module alu_result_collector #(
    parameter int LAT_ARITH = 4,
    parameter int LAT_LOGIC = 31,
    parameter int LAT_SHIFT = 27,
    parameter int DEPTH     = 32,
    parameter int PTR_W     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [4:0]       issue_opcode,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    input  logic [63:0]      alu_out,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [63:0]      wb_data,
    output logic [1:0]       wb_class,
    output logic [PTR_W:0]   inflight_cnt,
    output logic             illegal_op
);

    localparam logic [1:0] C_CLASS_ARITH   = 2'b00;
    localparam logic [1:0] C_CLASS_LOGIC   = 2'b01;
    localparam logic [1:0] C_CLASS_SHIFT   = 2'b10;
    localparam logic [1:0] C_CLASS_ILLEGAL = 2'b11;

    localparam logic [PTR_W-1:0] C_LAT_ARITH = PTR_W'(LAT_ARITH);
    localparam logic [PTR_W-1:0] C_LAT_LOGIC = PTR_W'(LAT_LOGIC);
    localparam logic [PTR_W-1:0] C_LAT_SHIFT = PTR_W'(LAT_SHIFT);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTR_W-1:0] ptr_q,          ptr_d;
    logic [DEPTH-1:0] slot_valid_q,   slot_valid_d;
    logic [4:0]       slot_rd_q    [DEPTH];
    logic [4:0]       slot_rd_d    [DEPTH];
    logic [1:0]       slot_class_q [DEPTH];
    logic [1:0]       slot_class_d [DEPTH];

    logic             wb_valid_q,     wb_valid_d;
    logic [4:0]       wb_rd_q,        wb_rd_d;
    logic [63:0]      wb_data_q,      wb_data_d;
    logic [1:0]       wb_class_q,     wb_class_d;
    logic [PTR_W:0]   inflight_cnt_q, inflight_cnt_d;
    logic             illegal_op_q,   illegal_op_d;

    // ------------------------------------------------------------------
    // Issue-side decode
    // ------------------------------------------------------------------
    logic [1:0]       issue_class;
    logic [PTR_W-1:0] issue_lat;
    logic [PTR_W-1:0] target_slot;
    logic             hazard;
    logic             issue_accept;
    logic             consume;

    // Low opcode bits only matter to the ALU itself.
    logic             unused_opcode_bits;
    assign unused_opcode_bits = ^issue_opcode[2:0];

    assign issue_class = issue_opcode[4:3];

    always_comb begin
        issue_lat = '0;
        case (issue_class)
            C_CLASS_ARITH: issue_lat = C_LAT_ARITH;
            C_CLASS_LOGIC: issue_lat = C_LAT_LOGIC;
            C_CLASS_SHIFT: issue_lat = C_LAT_SHIFT;
            default:       issue_lat = '0;
        endcase
    end

    // DEPTH is a power of two, so the natural wrap of the add is the modulo.
    assign target_slot = ptr_q + issue_lat;

    assign issue_ready  = !slot_valid_q[target_slot]
                        && (issue_class != C_CLASS_ILLEGAL)
                        && !hazard;
    assign issue_accept = issue_valid && issue_ready;
    assign consume      = slot_valid_q[ptr_q];

    // ------------------------------------------------------------------
    // Optional destination-register hazard tracking
    // ------------------------------------------------------------------
`ifdef DEST_HAZARD_EN
    logic [31:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (consume) begin
            busy_d[slot_rd_q[ptr_q]] = 1'b0;
        end
        // Set after clear: a new op to the same rd keeps the bit busy.
        if (issue_accept) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard = busy_q[issue_rd];
`else
    assign hazard = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Wheel update: consume slot[ptr] and book slot[target] in one edge.
    // LAT >= 1 keeps the two indices distinct.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d        = ptr_q + 1'b1;
        slot_valid_d = slot_valid_q;
        slot_rd_d    = slot_rd_q;
        slot_class_d = slot_class_q;

        slot_valid_d[ptr_q] = 1'b0;
        if (issue_accept) begin
            slot_valid_d[target_slot] = 1'b1;
            slot_rd_d[target_slot]    = issue_rd;
            slot_class_d[target_slot] = issue_class;
        end
    end

    // ------------------------------------------------------------------
    // Writeback capture and bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wb_valid_d     = consume;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        wb_class_d     = wb_class_q;
        inflight_cnt_d = inflight_cnt_q;
        illegal_op_d   = issue_valid && (issue_class == C_CLASS_ILLEGAL);

        if (consume) begin
            wb_rd_d    = slot_rd_q[ptr_q];
            wb_class_d = slot_class_q[ptr_q];
            wb_data_d  = alu_out;
        end

        case ({issue_accept, consume})
            2'b10:   inflight_cnt_d = inflight_cnt_q + 1'b1;
            2'b01:   inflight_cnt_d = inflight_cnt_q - 1'b1;
            default: inflight_cnt_d = inflight_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q          <= '0;
            slot_valid_q   <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            wb_class_q     <= '0;
            inflight_cnt_q <= '0;
            illegal_op_q   <= 1'b0;
        end else begin
            ptr_q          <= ptr_d;
            slot_valid_q   <= slot_valid_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            wb_class_q     <= wb_class_d;
            inflight_cnt_q <= inflight_cnt_d;
            illegal_op_q   <= illegal_op_d;
        end
    end

    // Slot payload is qualified by slot_valid_q and needs no reset.
    always_ff @(posedge clk) begin
        slot_rd_q    <= slot_rd_d;
        slot_class_q <= slot_class_d;
    end

    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_class     = wb_class_q;
    assign inflight_cnt = inflight_cnt_q;
    assign illegal_op   = illegal_op_q;

endmodule
`default_nettype wire
